// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register file / pending-write scoreboard.
package regfile_scoreboard_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int PEND_W     = 2;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Saturation value of a pending-write counter and the unit step.
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_NONE = {PEND_W{1'b0}};

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       reg_data_t;
  typedef logic [PEND_W-1:0]     pend_cnt_t;

endpackage

// File: rtl/regfile_scoreboard_array.sv
// Register storage with one write port and two bypassing combinational read ports.
module regfile_array
  import regfile_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  wb_write,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data
);

  reg_data_t regs_r [NREGS];

  // Storage update: clear on reset, otherwise accept writebacks except to x0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_write && (wb_addr != REG_ZERO)) begin
      regs_r[wb_addr] <= wb_data;
    end else begin
      regs_r[0] <= '0;
    end
  end

  // Read port 1: x0 reads zero, a same-cycle writeback is forwarded, else the array.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr == REG_ZERO) begin
      rs1_data = '0;
    end else if (wb_write && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_r[rs1_addr];
    end
  end

  // Read port 2: same forwarding rules as port 1.
  always_comb begin
    rs2_data = '0;
    if (rs2_addr == REG_ZERO) begin
      rs2_data = '0;
    end else if (wb_write && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_r[rs2_addr];
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file plus per-register pending-write counters that generate the decode stall.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  wb_write,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  issue_valid,
  input  logic                  issue_writes,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  stall,
  output logic                  sb_error
);

  pend_cnt_t        pend_r [NREGS];
  logic             sb_error_r;

  logic [NREGS-1:0] wb_hit_s;
  logic [NREGS-1:0] inc_s;
  logic [NREGS-1:0] dec_s;
  logic             underflow_s;
  pend_cnt_t        eff1_s;
  pend_cnt_t        eff2_s;
  logic             raw1_s;
  logic             raw2_s;
  logic             full_s;
  logic             stall_s;
  logic             accept_s;

  regfile_array u_array (
    .clk      (clk),
    .reset    (reset),
    .wb_data  (wb_data),
    .wb_addr  (wb_addr),
    .wb_write (wb_write),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  // Decode which register the writeback retires; x0 is never a hit.
  always_comb begin
    wb_hit_s = '0;
    for (int r = 0; r < NREGS; r++) begin
      wb_hit_s[r] = wb_write && (wb_addr == REG_ADDR_W'(r)) && (r != 0);
    end
  end

  // Hazard detection: a retiring writeback counts as already done, so dependents
  // are released in the same cycle as their last pending write.
  always_comb begin
    eff1_s   = pend_r[rs1_addr] - PEND_W'(wb_hit_s[rs1_addr] && (pend_r[rs1_addr] != PEND_NONE));
    eff2_s   = pend_r[rs2_addr] - PEND_W'(wb_hit_s[rs2_addr] && (pend_r[rs2_addr] != PEND_NONE));
    raw1_s   = rs1_used && (rs1_addr != REG_ZERO) && (eff1_s != PEND_NONE);
    raw2_s   = rs2_used && (rs2_addr != REG_ZERO) && (eff2_s != PEND_NONE);
    full_s   = issue_writes && (issue_rd != REG_ZERO) &&
               (pend_r[issue_rd] == PEND_MAX) && !wb_hit_s[issue_rd];
    stall_s  = reset || (issue_valid && (raw1_s || raw2_s || full_s));
    accept_s = issue_valid && !stall_s;
  end

  // Per-register increment/decrement requests and underflow detection.
  always_comb begin
    inc_s       = '0;
    dec_s       = '0;
    underflow_s = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      inc_s[r] = accept_s && issue_writes && (issue_rd == REG_ADDR_W'(r));
      dec_s[r] = wb_hit_s[r] && (pend_r[r] != PEND_NONE);
      if (wb_hit_s[r] && (pend_r[r] == PEND_NONE)) begin
        underflow_s = 1'b1;
      end else begin
        underflow_s = underflow_s;
      end
    end
  end

  // Pending counters and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_r[r] <= PEND_NONE;
      end
      sb_error_r <= 1'b0;
    end else begin
      pend_r[0] <= PEND_NONE;
      for (int r = 1; r < NREGS; r++) begin
        case ({inc_s[r], dec_s[r]})
          2'b10:   pend_r[r] <= pend_r[r] + PEND_ONE;
          2'b01:   pend_r[r] <= pend_r[r] - PEND_ONE;
          default: pend_r[r] <= pend_r[r];
        endcase
      end
      if (underflow_s) begin
        sb_error_r <= 1'b1;
      end else begin
        sb_error_r <= sb_error_r;
      end
    end
  end

  assign stall    = stall_s;
  assign sb_error = sb_error_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: the driver pushes expected outputs from a reference model,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_data = 32'd0;
  logic [4:0]  wb_addr = 5'd0;
  logic        wb_write = 1'b0;
  logic [4:0]  rs1_addr = 5'd0, rs2_addr = 5'd0;
  logic        rs1_used = 1'b0, rs2_used = 1'b0;
  logic        issue_valid = 1'b0, issue_writes = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [31:0] rs1_data, rs2_data;
  logic        stall, sb_error;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .wb_data(wb_data), .wb_addr(wb_addr), .wb_write(wb_write),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_rd(issue_rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        sberr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural values, in-flight write counts, error flag.
  logic [31:0] m_regs [32];
  int          m_pend [32];
  bit          m_sberr;

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit wbw,
                                         input logic [4:0] wba, input logic [31:0] wbd);
    if (a == 5'd0) return 32'd0;
    if (wbw && wba == a) return wbd;
    return m_regs[a];
  endfunction

  // A source is busy if writes remain in flight after any write retiring this cycle.
  function automatic bit m_busy(input logic [4:0] a, input bit wbw, input logic [4:0] wba);
    int left;
    if (a == 5'd0) return 1'b0;
    left = m_pend[a];
    if (wbw && wba == a && left > 0) left = left - 1;
    return left > 0;
  endfunction

  task automatic step(input bit rst, input bit wbw, input logic [4:0] wba, input logic [31:0] wbd,
                      input logic [4:0] r1, input logic [4:0] r2, input bit u1, input bit u2,
                      input bit iv, input bit iw, input logic [4:0] ird, input bit chk);
    exp_t e;
    bit   full, stl, acc;
    reset = rst; wb_write = wbw; wb_addr = wba; wb_data = wbd;
    rs1_addr = r1; rs2_addr = r2; rs1_used = u1; rs2_used = u2;
    issue_valid = iv; issue_writes = iw; issue_rd = ird;
    full = iw && ird != 5'd0 && m_pend[ird] == 3 && !(wbw && wba == ird);
    stl  = rst || (iv && ((u1 && m_busy(r1, wbw, wba)) || (u2 && m_busy(r2, wbw, wba)) || full));
    acc  = iv && !stl;
    e.rs1 = m_read(r1, wbw, wba, wbd);
    e.rs2 = m_read(r2, wbw, wba, wbd);
    e.stall = stl;
    e.sberr = m_sberr;
    if (chk) exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_pend[i] = 0; end
      m_sberr = 1'b0;
    end else begin
      if (wbw && wba != 5'd0) begin
        m_regs[wba] = wbd;
        if (m_pend[wba] == 0) m_sberr = 1'b1;
        else m_pend[wba] = m_pend[wba] - 1;
      end
      if (acc && iw && ird != 5'd0) m_pend[ird] = m_pend[ird] + 1;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 1'b0, 5'd0, 32'd0, r1, r2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  // Monitor: compare every presented expectation halfway through the cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks += 4;
      if (rs1_data !== e.rs1) begin errors++; $display("FAIL rs1_data: got %h expected %h at %0t", rs1_data, e.rs1, $time); end
      if (rs2_data !== e.rs2) begin errors++; $display("FAIL rs2_data: got %h expected %h at %0t", rs2_data, e.rs2, $time); end
      if (stall !== e.stall) begin errors++; $display("FAIL stall: got %b expected %b at %0t", stall, e.stall, $time); end
      if (sb_error !== e.sberr) begin errors++; $display("FAIL sb_error: got %b expected %b at %0t", sb_error, e.sberr, $time); end
    end
  end

  initial begin
    int pl[$];
    bit rst, wbw, u1, u2, iv, iw;
    logic [4:0] wba, r1, r2, ird;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_pend[i] = 0; end
    m_sberr = 1'b0;

    // Reset: first cycle unchecked (state undefined before the first edge).
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
    idle(5'd1, 5'd2);

    // RAW on x5 released in the writeback cycle, then read from the array.
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
    repeat (2) step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);

    // Saturation on x7: three accepted, fourth stalls, accepted alongside a writeback.
    repeat (3) step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
    step(1'b0, 1'b1, 5'd7, 32'h00000077, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
    repeat (3) step(1'b0, 1'b1, 5'd7, $urandom, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);

    // Simultaneous accept and writeback on x3 leaves one write pending.
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'h34, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);

    // x0: writes dropped, rd=0 issues never count or stall.
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1);

    // Underflow on x9: data still written, sticky error until reset.
    step(1'b0, 1'b1, 5'd9, 32'h12, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    repeat (3) idle(5'd9, 5'd5);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    idle(5'd9, 5'd7);

    // Random traffic on a small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      wbw = ($urandom_range(0, 1) == 1);
      pl.delete();
      for (int r = 1; r < 8; r++) if (m_pend[r] > 0) pl.push_back(r);
      if (pl.size() != 0 && $urandom_range(0, 9) != 0)
        wba = 5'(pl[$urandom_range(0, pl.size() - 1)]);
      else
        wba = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
      u1 = $urandom_range(0, 1) == 1; u2 = $urandom_range(0, 1) == 1;
      iv = $urandom_range(0, 3) != 0; iw = $urandom_range(0, 4) < 3;
      ird = 5'($urandom_range(0, 7));
      step(rst, wbw, wba, $urandom, r1, r2, u1, u2, iv, iw, ird, 1'b1);
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Consumer end of the writeback feedback path: 32x32 integer register file, 2 combinational read ports and 1 write port fed by the writeback stage's reg_data_out / reg_addr_out / reg_write_out.
- Holds a per-register pending-write scoreboard: set at issue, cleared when the matching writeback arrives. Generates the decode stall for RAW hazards and in-flight saturation.
- Sits between the decode stage (read/issue side) and the writeback stage (write side).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero.
- PEND_W, 2, width of each pending-write counter; at most 2^PEND_W-1 writes to one register may be in flight.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_data  in  XLEN  writeback data.
- wb_addr  in  5  writeback destination register.
- wb_write  in  1  writeback strobe.
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rs1_used  in  1  decode instruction reads rs1.
- rs2_used  in  1  decode instruction reads rs2.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_writes  in  1  presented instruction writes a register.
- issue_rd  in  5  destination of presented instruction.
- rs1_data  out  XLEN  read data port 1 (combinational).
- rs2_data  out  XLEN  read data port 2 (combinational).
- stall  out  1  decode must hold; instruction not accepted.
- sb_error  out  1  sticky: writeback arrived for a register with no pending write.

Behaviour:
- Reset, checked at clock edge: all registers := 0, all counters := 0, sb_error := 0.
- While reset is high: stall = 1, and writeback and issue are ignored.
- Write: on edge, if wb_write && wb_addr != 0 && !reset, then reg[wb_addr] := wb_data. Writes to x0 are dropped.
- Read (combinational), per port:
  - addr == 0 gives 0.
  - Otherwise, if wb_write && wb_addr == addr, gives wb_data (same-cycle bypass).
  - Otherwise gives reg[addr].
- wb_hit(r) = wb_write && wb_addr == r && r != 0.
- Effective pending: eff(r) = pend[r] - (wb_hit(r) && pend[r] != 0).
- stall = reset || (issue_valid && (raw1 || raw2 || full)), where:
  - raw1 = rs1_used && rs1_addr != 0 && eff(rs1_addr) != 0
  - raw2 = rs2_used && rs2_addr != 0 && eff(rs2_addr) != 0
  - full = issue_writes && issue_rd != 0 && pend[issue_rd] == 2^PEND_W-1 && !wb_hit(issue_rd)
- accept = issue_valid && !stall.
- Counter update per register r != 0, per edge:
  - inc = accept && issue_writes && issue_rd == r; dec = wb_hit(r) && pend[r] != 0.
  - inc && !dec: +1. dec && !inc: -1. Both: unchanged. pend[0] is always 0.
- Underflow: wb_hit(r) with pend[r] == 0 means the register is still written, the counter stays 0, and sb_error := 1 (cleared only by reset).
- Latency: a written value is readable via bypass in the wb cycle, and from the array on the following cycle. A dependent instruction is released in the same cycle as the last pending writeback.
- Issue with issue_writes = 0, or issue_rd = 0, never touches counters.

Decomposition:
- Shared package: XLEN, NREGS, REG_ADDR_W = 5, PEND_W default, and constant REG_ZERO = 5'd0.
- Sub-module regfile_array: storage, write port, bypassing read ports (no scoreboard logic).
- Scoreboard counters and stall logic stay in the top module.

Test Plan:
- Reset, then read x1/x2 -> rs1_data = rs2_data = 0, stall = 0 after reset deasserts, sb_error = 0; stall = 1 during reset.
- Issue writer rd = 5, next cycle issue reader rs1 = 5 -> stall = 1 until cycle with wb_write = 1, wb_addr = 5, wb_data = 0xDEADBEEF; that cycle stall = 0, rs1_data = 0xDEADBEEF; next cycle array read returns 0xDEADBEEF.
- Three back-to-back issues writing rd = 7, fourth writer to rd = 7 with no wb -> stall = 1 (full); same cycle with wb to x7 -> accepted, pend[7] stays 3.
- Simultaneous accept writing rd = 3 and wb to x3 with pend[3] = 1 -> pend[3] remains 1; reader of x3 next cycle stalls.
- wb_write to x0 with 0xFFFFFFFF, read rs1 = 0 -> 0; issue_rd = 0 never stalls or counts.
- wb to x9 with pend[9] = 0, wb_data = 0x12 -> reg[9] = 0x12, sb_error = 1 and stays 1 until reset.
